// File: rtl/nios_system_mutex_client.sv
// Avalon-MM master that acquires/releases the hardware mutex for a local hardware block.
// Define MUTEX_CLIENT_INIT_CHECK_EN to read (and clear) the mutex reset flag after reset.
module nios_system_mutex_client #(
    parameter logic [15:0] OWNER_ID    = 16'h0001,
    parameter logic [15:0] LOCK_VALUE  = 16'h0001,
    parameter logic [7:0]  MAX_RETRIES = 8'd8,
    parameter logic [7:0]  BACKOFF     = 8'd16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        acquire_req,
    input  logic        release_req,
    output logic        locked,
    output logic        busy,
    output logic        acquire_fail,
    output logic        first_boot,
    output logic        avm_address,
    output logic        avm_chipselect,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    localparam logic [31:0] LOCK_WORD = {OWNER_ID, LOCK_VALUE};
    localparam logic [31:0] FREE_WORD = {OWNER_ID, 16'h0000};

    typedef enum logic [2:0] {
`ifdef MUTEX_CLIENT_INIT_CHECK_EN
        S_INIT_RD,
        S_INIT_WR,
`endif
        S_IDLE,
        S_ACQ_WR,
        S_ACQ_RD,
        S_BACKOFF,
        S_LOCKED,
        S_REL_WR
    } state_t;

`ifdef MUTEX_CLIENT_INIT_CHECK_EN
    localparam state_t RESET_STATE = S_INIT_RD;
    localparam logic   BUSY_RESET  = 1'b1;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   BUSY_RESET  = 1'b0;
`endif

    state_t      state, state_next;
    logic [7:0]  attempt_cnt, attempt_next, attempt_inc;
    logic [7:0]  backoff_cnt, backoff_next;
    logic        fail_next;
    logic        xfer_done;
    logic        rd_next, wr_next, addr_next;
    logic [31:0] wdata_next;

    assign avm_chipselect = avm_read | avm_write;
    assign xfer_done      = (avm_read | avm_write) & ~avm_waitrequest;
    assign attempt_inc    = (attempt_cnt == 8'hFF) ? attempt_cnt : attempt_cnt + 8'd1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next   = state;
        attempt_next = attempt_cnt;
        backoff_next = backoff_cnt;
        fail_next    = 1'b0;
        case (state)
`ifdef MUTEX_CLIENT_INIT_CHECK_EN
            S_INIT_RD: if (xfer_done) state_next = avm_readdata[0] ? S_INIT_WR : S_IDLE;
            S_INIT_WR: if (xfer_done) state_next = S_IDLE;
`endif
            S_IDLE: begin
                if (acquire_req) begin
                    attempt_next = 8'd0;
                    state_next   = S_ACQ_WR;
                end
            end
            S_ACQ_WR: if (xfer_done) state_next = S_ACQ_RD;
            S_ACQ_RD: begin
                if (xfer_done) begin
                    if (avm_readdata == LOCK_WORD) begin
                        state_next = S_LOCKED;
                    end else begin
                        attempt_next = attempt_inc;
                        if (MAX_RETRIES != 8'd0 && attempt_inc == MAX_RETRIES) begin
                            fail_next  = 1'b1;
                            state_next = S_IDLE;
                        end else if (BACKOFF == 8'd0) begin
                            state_next = S_ACQ_WR;
                        end else begin
                            backoff_next = BACKOFF;
                            state_next   = S_BACKOFF;
                        end
                    end
                end
            end
            S_BACKOFF: begin
                if (backoff_cnt <= 8'd1) state_next = S_ACQ_WR;
                else                     backoff_next = backoff_cnt - 8'd1;
            end
            S_LOCKED: if (release_req) state_next = S_REL_WR;
            S_REL_WR: if (xfer_done) state_next = S_IDLE;
            default:  state_next = RESET_STATE;
        endcase
    end

    // Bus outputs are registered from the next state so a reset clears them immediately.
    always_comb begin
        rd_next    = 1'b0;
        wr_next    = 1'b0;
        addr_next  = 1'b0;
        wdata_next = 32'h0;
        case (state_next)
`ifdef MUTEX_CLIENT_INIT_CHECK_EN
            S_INIT_RD: begin rd_next = 1'b1; addr_next = 1'b1; end
            S_INIT_WR: begin wr_next = 1'b1; addr_next = 1'b1; end
`endif
            S_ACQ_WR: begin wr_next = 1'b1; wdata_next = LOCK_WORD; end
            S_ACQ_RD: rd_next = 1'b1;
            S_REL_WR: begin wr_next = 1'b1; wdata_next = FREE_WORD; end
            default:  ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= RESET_STATE;
            attempt_cnt   <= 8'd0;
            backoff_cnt   <= 8'd0;
            locked        <= 1'b0;
            busy          <= BUSY_RESET;
            acquire_fail  <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= 1'b0;
            avm_writedata <= 32'h0;
        end else begin
            state         <= state_next;
            attempt_cnt   <= attempt_next;
            backoff_cnt   <= backoff_next;
            locked        <= (state_next == S_LOCKED) || (state_next == S_REL_WR);
            busy          <= (state_next != S_IDLE) && (state_next != S_LOCKED);
            acquire_fail  <= fail_next;
            avm_read      <= rd_next;
            avm_write     <= wr_next;
            avm_address   <= addr_next;
            avm_writedata <= wdata_next;
        end
    end

`ifdef MUTEX_CLIENT_INIT_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                            first_boot <= 1'b0;
        else if (state == S_INIT_RD && xfer_done) first_boot <= avm_readdata[0];
    end
`else
    assign first_boot = 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_mutex_client.sv
// Scoreboard bench for nios_system_mutex_client: a behavioural mutex slave, expected bus
// transfers queued by the stimulus tasks and popped by an independent bus monitor.
`timescale 1ns/1ps
module tb_nios_system_mutex_client;

    localparam int          MAXR       = 4;
    localparam int          BO         = 16;
    localparam logic [31:0] LOCK_WORD  = 32'h0001_0001;
    localparam logic [31:0] FREE_WORD  = 32'h0001_0000;
    localparam logic [31:0] OTHER_WORD = 32'h0002_0005;
`ifdef MUTEX_CLIENT_INIT_CHECK_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        acquire_req = 1'b0;
    logic        release_req = 1'b0;
    logic        locked, busy, acquire_fail, first_boot;
    logic        avm_address, avm_chipselect, avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest = 1'b0;

    nios_system_mutex_client #(
        .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
        .MAX_RETRIES(8'(MAXR)), .BACKOFF(8'(BO))
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .acquire_req(acquire_req), .release_req(release_req),
        .locked(locked), .busy(busy), .acquire_fail(acquire_fail), .first_boot(first_boot),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect),
        .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        addr;
        logic [31:0] data;
    } xfer_t;

    xfer_t exp_q[$];
    int    wr_cyc[$];
    int    rd_cyc[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cycle = 0;
    int    fail_pulses = 0;
    logic  prev_fail = 1'b0;

    // Behavioural mutex slave: value register at address 0, reset flag at address 1.
    logic [31:0] mutex_val = 32'h0;
    logic        reset_flag = 1'b1;
    int          reject_left = 0;
    bit          rand_wait = 1'b0;
    logic        wait_force = 1'b0;

    assign avm_readdata = avm_address ? {31'd0, reset_flag} : mutex_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic wr, input logic addr, input logic [31:0] data);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.data = data;
        exp_q.push_back(x);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : wait_force;
        end
    end

    // Monitor: pops the scoreboard on every completed transfer and plays the mutex slave.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (reset_n && (avm_read || avm_write) && !avm_waitrequest) begin
                xfer_t e;
                logic [31:0] d;
                d = avm_write ? avm_writedata : avm_readdata;
                check("one_strobe", {31'd0, avm_read & avm_write}, 32'd0);
                check("chipselect", {31'd0, avm_chipselect}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_xfer: got wr=%0b addr=%0b data=%h, expected none",
                             avm_write, avm_address, d);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_kind", {31'd0, avm_write}, {31'd0, e.wr});
                    check("xfer_addr", {31'd0, avm_address}, {31'd0, e.addr});
                    check("xfer_data", d, e.data);
                end
                if (avm_write) wr_cyc.push_back(cycle);
                else           rd_cyc.push_back(cycle);
                if (avm_write && !avm_address) begin
                    if (mutex_val[15:0] == 16'h0 || mutex_val[31:16] == avm_writedata[31:16])
                        mutex_val = avm_writedata;
                    else if (reject_left == 0)
                        mutex_val = avm_writedata;
                    else
                        reject_left--;
                end
                if (avm_write && avm_address) reset_flag = 1'b0;
            end
            if (acquire_fail) begin
                check("fail_pulse_width", {31'd0, prev_fail}, 32'd0);
                fail_pulses++;
            end
            prev_fail = acquire_fail;
        end
    end

    task automatic wait_not_busy(input string name);
        int g = 0;
        while (busy && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: busy still %0b, expected 0", name, busy);
        end
    endtask

    task automatic wait_unlocked(input string name);
        int g = 0;
        while (locked && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) begin
            n_checks++; n_fail++;
            $display("FAIL %s_timeout: locked still %0b, expected 0", name, locked);
        end
    endtask

    task automatic pulse_acquire(input logic with_release);
        @(negedge clk);
        acquire_req = 1'b1;
        release_req = with_release;
        @(negedge clk);
        acquire_req = 1'b0;
        release_req = 1'b0;
    endtask

    task automatic pulse_release(input logic with_acquire);
        @(negedge clk);
        release_req = 1'b1;
        acquire_req = with_acquire;
        @(negedge clk);
        release_req = 1'b0;
        acquire_req = 1'b0;
    endtask

    task automatic apply_reset(input logic flag);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_fail", {31'd0, acquire_fail}, 32'd0);
        check("rst_first_boot", {31'd0, first_boot}, 32'd0);
        check("rst_busy", {31'd0, busy}, {31'd0, BUSY_RST});
        check("rst_strobes", {29'd0, avm_read, avm_write, avm_chipselect}, 32'd0);
        check("rst_addr_data", {avm_writedata[30:0], avm_address}, 32'd0);
        exp_q.delete();
        mutex_val   = 32'h0;
        reset_flag  = flag;
        reject_left = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
`ifdef MUTEX_CLIENT_INIT_CHECK_EN
        push(1'b0, 1'b1, {31'd0, flag});
        if (flag) push(1'b1, 1'b1, 32'h0);
        @(negedge clk);
        check("init_busy", {31'd0, busy}, 32'd1);
        wait_not_busy("init");
        @(negedge clk);
        check("init_first_boot", {31'd0, first_boot}, {31'd0, flag});
        check("init_queue_empty", exp_q.size(), 32'd0);
`else
        @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_first_boot", {31'd0, first_boot}, 32'd0);
`endif
    endtask

    // Free mutex, no stalls: write in cycle 1, read in cycle 2, locked from cycle 3.
    task automatic acquire_free_latency();
        push(1'b1, 1'b0, LOCK_WORD);
        push(1'b0, 1'b0, LOCK_WORD);
        pulse_acquire(1'b0);
        check("lat_c1_write", {31'd0, avm_write}, 32'd1);
        check("lat_c1_addr", {31'd0, avm_address}, 32'd0);
        check("lat_c1_wdata", avm_writedata, LOCK_WORD);
        check("lat_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("lat_c2_read", {31'd0, avm_read}, 32'd1);
        check("lat_c2_locked", {31'd0, locked}, 32'd0);
        @(negedge clk);
        check("lat_c3_locked", {31'd0, locked}, 32'd1);
        check("lat_c3_busy", {31'd0, busy}, 32'd0);
        check("lat_c3_strobes", {30'd0, avm_read, avm_write}, 32'd0);
    endtask

    task automatic release_latency();
        push(1'b1, 1'b0, FREE_WORD);
        pulse_release(1'b0);
        check("rel_c1_write", {31'd0, avm_write}, 32'd1);
        check("rel_c1_wdata", avm_writedata, FREE_WORD);
        check("rel_c1_locked", {31'd0, locked}, 32'd1);
        @(negedge clk);
        check("rel_c2_locked", {31'd0, locked}, 32'd0);
        check("rel_c2_busy", {31'd0, busy}, 32'd0);
    endtask

    // Reference model: with another owner rejecting k writes, the client wins on attempt
    // k+1 if that is within the retry limit, otherwise it gives up after MAXR attempts.
    task automatic acquire_random(input int iter);
        bit holds;
        int k, fails, attempts, f0;
        bit success;
        holds = ($urandom_range(0, 1) == 1);
        k     = $urandom_range(0, 6);
        if (holds) begin
            mutex_val   = OTHER_WORD;
            reject_left = k;
        end
        success  = !holds || (k < MAXR);
        fails    = holds ? ((k < MAXR) ? k : MAXR) : 0;
        attempts = success ? fails + 1 : MAXR;
        for (int i = 0; i < attempts; i++) begin
            push(1'b1, 1'b0, LOCK_WORD);
            push(1'b0, 1'b0, (i < fails) ? OTHER_WORD : LOCK_WORD);
        end
        f0 = fail_pulses;
        pulse_acquire(1'($urandom_range(0, 1)));
        wait_not_busy("rand_acq");
        @(negedge clk);
        check($sformatf("rand_locked_%0d", iter), {31'd0, locked}, {31'd0, success});
        check($sformatf("rand_failpulse_%0d", iter), fail_pulses - f0, success ? 32'd0 : 32'd1);
        check($sformatf("rand_queue_%0d", iter), exp_q.size(), 32'd0);
        if (success) begin
            push(1'b1, 1'b0, FREE_WORD);
            pulse_release(1'($urandom_range(0, 1)));
            wait_unlocked("rand_rel");
            @(negedge clk);
            check($sformatf("rand_rel_idle_%0d", iter), {30'd0, busy, locked}, 32'd0);
            check($sformatf("rand_rel_queue_%0d", iter), exp_q.size(), 32'd0);
        end
        mutex_val = 32'h0;
    endtask

    initial begin
        int f0;
        apply_reset(1'b1);

        acquire_free_latency();

        // acquire_req is ignored while the lock is held.
        pulse_acquire(1'b0);
        repeat (3) @(negedge clk);
        check("locked_ignores_acq", {30'd0, locked, busy}, 32'd2);

        release_latency();

        // A second release in IDLE produces no transfer.
        pulse_release(1'b0);
        repeat (3) @(negedge clk);
        check("idle_ignores_rel", {29'd0, locked, busy, avm_write}, 32'd0);

        // Mutex held elsewhere: MAXR write/read pairs spaced BO idle cycles, then fail.
        mutex_val   = OTHER_WORD;
        reject_left = 1000;
        wr_cyc.delete();
        rd_cyc.delete();
        for (int i = 0; i < MAXR; i++) begin
            push(1'b1, 1'b0, LOCK_WORD);
            push(1'b0, 1'b0, OTHER_WORD);
        end
        f0 = fail_pulses;
        pulse_acquire(1'b0);
        wait_not_busy("retry");
        @(negedge clk);
        check("retry_locked", {31'd0, locked}, 32'd0);
        check("retry_failpulse", fail_pulses - f0, 32'd1);
        check("retry_writes", wr_cyc.size(), MAXR);
        check("retry_reads", rd_cyc.size(), MAXR);
        for (int i = 0; i + 1 < MAXR && i + 1 < wr_cyc.size() && i < rd_cyc.size(); i++)
            check($sformatf("retry_gap_%0d", i), wr_cyc[i+1] - rd_cyc[i], BO + 1);
        check("retry_queue", exp_q.size(), 32'd0);
        mutex_val   = 32'h0;
        reject_left = 0;

        // Write stalled by waitrequest for 5 cycles: held stable for 6, completes once.
        wait_force = 1'b1;
        push(1'b1, 1'b0, LOCK_WORD);
        push(1'b0, 1'b0, LOCK_WORD);
        pulse_acquire(1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 4) wait_force = 1'b0;
            check($sformatf("stall_hold_%0d", i),
                  {avm_writedata[31:3], avm_write, avm_read, avm_address},
                  {LOCK_WORD[31:3], 3'b100});
            check($sformatf("stall_wdata_%0d", i), avm_writedata, LOCK_WORD);
        end
        wait_not_busy("stall");
        check("stall_locked", {31'd0, locked}, 32'd1);
        check("stall_queue", exp_q.size(), 32'd0);
        release_latency();

        // Reset while a read is stalled: strobes drop at once, then a fresh acquire works.
        push(1'b1, 1'b0, LOCK_WORD);
        pulse_acquire(1'b0);
        wait_force = 1'b1;
        @(negedge clk);
        check("midrd_read", {31'd0, avm_read}, 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrd_strobes", {29'd0, avm_read, avm_write, avm_chipselect}, 32'd0);
        check("midrd_locked", {31'd0, locked}, 32'd0);
        wait_force = 1'b0;
        apply_reset(1'b1);
        acquire_free_latency();
        release_latency();

`ifdef MUTEX_CLIENT_INIT_CHECK_EN
        apply_reset(1'b0);
`endif

        rand_wait = 1'b1;
        for (int it = 0; it < 25; it++) acquire_random(it);
        rand_wait = 1'b0;

        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
